// File: rtl/cnn_pkg.sv
// Shared constants and state encoding for the CNN datapath controllers.
//
// Holds the image/kernel geometry, datapath widths and the controller state
// encoding shared by the convolution scheduler and the max-pool controller.
// tap_offset() maps a row-major kernel tap index to its image address offset
// from the top-left pixel of the window.

package cnn_pkg;

  localparam int unsigned DIM     = 28;            // input image side, pixels
  localparam int unsigned K       = 3;             // kernel side
  localparam int unsigned OUT_DIM = DIM - K + 1;   // valid-convolution output side
  localparam int unsigned PIX_W   = 8;             // pixel and weight width
  localparam int unsigned ACC_W   = 20;            // accumulator/result width
  localparam int unsigned NTAPS   = K * K;         // taps per window
  localparam int unsigned IDX_W   = 5;             // output row/column index width
  localparam int unsigned TAP_W   = 4;             // tap counter width

  // Controller state encoding, also decoded by the max-pool controller.
  localparam logic [2:0] STATE_IDLE  = 3'd0;
  localparam logic [2:0] STATE_FETCH = 3'd1;
  localparam logic [2:0] STATE_DRAIN = 3'd2;
  localparam logic [2:0] STATE_EMIT  = 3'd3;
  localparam logic [2:0] STATE_DONE  = 3'd4;

  typedef enum logic [2:0] {
    StIdle  = STATE_IDLE,
    StFetch = STATE_FETCH,
    StDrain = STATE_DRAIN,
    StEmit  = STATE_EMIT,
    StDone  = STATE_DONE
  } conv_state_e;

  // Address offset of tap t relative to the window's top-left pixel.
  function automatic int unsigned tap_offset(int unsigned tap);
    return (tap / K) * DIM + (tap % K);
  endfunction

endpackage

// File: rtl/conv_tap_mac.sv
// Tap-serial multiply-accumulate for the convolution scheduler.
//
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   clr       zero the accumulator (wins over en)
//   en        add pix * wgt into the accumulator
//   pix, wgt  unsigned 8-bit pixel and weight
//   sum       registered accumulator value

module conv_tap_mac
  import cnn_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [PIX_W-1:0] pix,
  input  logic [PIX_W-1:0] wgt,
  output logic [ACC_W-1:0] sum
);

  logic [2*PIX_W-1:0] prod;
  logic [ACC_W-1:0]   sum_q;
  logic [ACC_W-1:0]   sum_d;

  always_comb begin
    prod  = {{PIX_W{1'b0}}, pix} * {{PIX_W{1'b0}}, wgt};
    sum_d = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (en) begin
      // 9 full-scale products still fit in ACC_W, so no saturation is needed.
      sum_d = sum_q + {{(ACC_W - 2 * PIX_W){1'b0}}, prod};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/conv_window_scheduler.sv
// 3x3 valid-convolution scheduler over a DIM x DIM image in a 1-port sync RAM.
//
// Walks output positions row-major. Per position: 9 FETCH cycles issue one tap
// read each, a DRAIN cycle folds in the last tap (RAM data lags img_re by one
// cycle), then EMIT holds the result until the downstream accepts it.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start                 begin a frame (sampled in IDLE only)
//   abort                 synchronous cancel of the running frame
//   kernel_in             9 unsigned weights, tap t at [8t+7:8t], latched on start
//   img_re, img_raddr     registered image RAM read request
//   img_rdata             RAM data, valid one cycle after img_re
//   out_valid, out_ready  result stream handshake
//   out_data              convolution sum
//   out_row, out_col      output position of out_data
//   busy                  high whenever not IDLE
//   done                  one-cycle pulse after the final result is accepted

module conv_window_scheduler
  import cnn_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [NTAPS*PIX_W-1:0] kernel_in,
  output logic                   img_re,
  output logic [ADDR_W-1:0]      img_raddr,
  input  logic [PIX_W-1:0]       img_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_data,
  output logic [IDX_W-1:0]       out_row,
  output logic [IDX_W-1:0]       out_col,
  output logic                   busy,
  output logic                   done
);

  localparam logic [IDX_W-1:0]  LastIdx = IDX_W'(OUT_DIM - 1);
  localparam logic [TAP_W-1:0]  LastTap = TAP_W'(NTAPS - 1);
  // Stepping from the last column to the next row's first column moves the
  // window base by K pixels (the columns skipped at the row end).
  localparam logic [ADDR_W-1:0] RowSkip = ADDR_W'(K);

  conv_state_e state_q, state_d;

  logic [TAP_W-1:0]       tap_q, tap_d;
  logic [IDX_W-1:0]       row_q, row_d;
  logic [IDX_W-1:0]       col_q, col_d;
  logic [ADDR_W-1:0]      base_q, base_d;
  logic [ADDR_W-1:0]      raddr_q, raddr_d;
  logic                   re_q, re_d;
  logic [NTAPS*PIX_W-1:0] kernel_q;
  logic                   kernel_load;

  logic                   mac_clr;
  logic                   mac_en;
  logic [TAP_W-1:0]       wsel;
  logic [PIX_W-1:0]       wgt;
  logic [ADDR_W-1:0]      tap_off;
  logic [ACC_W-1:0]       acc_sum;
  logic                   last_pos;

  assign last_pos = (row_q == LastIdx) && (col_q == LastIdx);

  // Next-state, counter and read-request logic.
  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    row_d       = row_q;
    col_d       = col_q;
    base_d      = base_q;
    re_d        = 1'b0;
    mac_clr     = 1'b0;
    mac_en      = 1'b0;
    kernel_load = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          kernel_load = 1'b1;
          mac_clr     = 1'b1;
          row_d       = '0;
          col_d       = '0;
          base_d      = '0;
          tap_d       = '0;
          re_d        = 1'b1;
          state_d     = StFetch;
        end
      end
      StFetch: begin
        // Data for tap t-1 arrives while tap t is being requested.
        mac_en = (tap_q != '0);
        if (tap_q == LastTap) begin
          state_d = StDrain;
        end else begin
          tap_d = tap_q + TAP_W'(1);
          re_d  = 1'b1;
        end
      end
      StDrain: begin
        mac_en  = 1'b1;
        state_d = StEmit;
      end
      StEmit: begin
        if (out_ready) begin
          mac_clr = 1'b1;
          if (last_pos) begin
            state_d = StDone;
          end else begin
            if (col_q == LastIdx) begin
              col_d  = '0;
              row_d  = row_q + IDX_W'(1);
              base_d = base_q + RowSkip;
            end else begin
              col_d  = col_q + IDX_W'(1);
              base_d = base_q + ADDR_W'(1);
            end
            tap_d   = '0;
            re_d    = 1'b1;
            state_d = StFetch;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides everything, including a same-cycle EMIT handshake.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      re_d    = 1'b0;
      mac_en  = 1'b0;
      mac_clr = 1'b1;
    end
  end

  // Constant offset table indexed by the tap about to be requested.
  always_comb begin
    tap_off = '0;
    for (int t = 0; t < NTAPS; t++) begin
      if (tap_d == TAP_W'(t)) begin
        tap_off = ADDR_W'(tap_offset(t));
      end
    end
  end

  assign raddr_d = re_d ? (base_d + tap_off) : raddr_q;

  // Weight for the tap whose data is on img_rdata this cycle.
  always_comb begin
    wsel = (state_q == StDrain) ? LastTap : (tap_q - TAP_W'(1));
    wgt  = '0;
    for (int t = 0; t < NTAPS; t++) begin
      if (wsel == TAP_W'(t)) begin
        wgt = kernel_q[t*PIX_W +: PIX_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      tap_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      base_q   <= '0;
      raddr_q  <= '0;
      re_q     <= 1'b0;
      kernel_q <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      row_q   <= row_d;
      col_q   <= col_d;
      base_q  <= base_d;
      raddr_q <= raddr_d;
      re_q    <= re_d;
      if (kernel_load) begin
        kernel_q <= kernel_in;
      end
    end
  end

  conv_tap_mac u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (mac_en),
    .pix (img_rdata),
    .wgt (wgt),
    .sum (acc_sum)
  );

  // All outputs come straight from registers; the accumulator is frozen in
  // EMIT, so out_data stays stable under backpressure.
  assign img_re    = re_q;
  assign img_raddr = raddr_q;
  assign out_valid = (state_q == StEmit);
  assign out_data  = acc_sum;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

endmodule
